router_fsm_ctrl: RTL and testbench
==================================

Name: router_fsm_ctrl

Overview:
- Packet-flow controller for the 1x3 router. Sits directly upstream of the synchronizer.
- Drives the synchronizer's detect_add and write_enb_reg, and consumes its fifo_full and soft_reset_0..2.
- Sequences each incoming packet through header decode, payload load, full-stall recovery, parity load and parity check.
- Throttles the source with busy.

Parameters:
- None.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- pkt_valid  input  1  source asserts for header+payload bytes; deasserts on the parity byte
- data_in  input  2  header destination address bits [1:0] (sampled only in DECODE_ADDRESS)
- fifo_full  input  1  full status of the addressed FIFO (from synchronizer)
- fifo_empty_0  input  1  output FIFO 0 empty
- fifo_empty_1  input  1  output FIFO 1 empty
- fifo_empty_2  input  1  output FIFO 2 empty
- soft_reset_0  input  1  timeout flush of FIFO 0
- soft_reset_1  input  1  timeout flush of FIFO 1
- soft_reset_2  input  1  timeout flush of FIFO 2
- parity_done  input  1  register block has captured the parity byte
- low_pkt_valid  input  1  register block saw pkt_valid fall while stalled
- detect_add  output  1  high in DECODE_ADDRESS
- lfd_state  output  1  high in LOAD_FIRST_DATA
- ld_state  output  1  high in LOAD_DATA
- laf_state  output  1  high in LOAD_AFTER_FULL
- full_state  output  1  high in FIFO_FULL_STATE
- write_enb_reg  output  1  FIFO write permitted
- rst_int_reg  output  1  high in CHECK_PARITY_ERROR
- busy  output  1  source must hold its current byte

Behaviour:
- One-hot or binary 3-bit state register; async reset forces DECODE_ADDRESS.
- All outputs are Moore, decoded from the current state only.
- Reset values: detect_add=1, busy=0, all other outputs 0.
- Address latch (2-bit register):
  - Loads data_in on the clock edge where state=DECODE_ADDRESS, pkt_valid=1 and data_in!=2'b11.
  - Cleared to 0 by reset.
- Transitions (evaluated each rising edge). Soft-reset override has top priority.
- Soft-reset override:
  - Applies in any state other than DECODE_ADDRESS.
  - Taken when soft_reset_N=1 for N equal to the latched address.
  - Next state is DECODE_ADDRESS.
  - soft_reset of a non-addressed port is ignored.
- DECODE_ADDRESS:
  - pkt_valid=1 and data_in=N (N=0..2) with fifo_empty_N=1: go to LOAD_FIRST_DATA.
  - pkt_valid=1 and data_in=N with fifo_empty_N=0: go to WAIT_TILL_EMPTY.
  - data_in=3 or pkt_valid=0: stay; the address latch is not updated.
- WAIT_TILL_EMPTY:
  - fifo_empty of the latched address=1: go to LOAD_FIRST_DATA; otherwise stay.
- LOAD_FIRST_DATA: go to LOAD_DATA unconditionally (exactly 1 cycle).
- LOAD_DATA:
  - fifo_full=1: go to FIFO_FULL_STATE.
  - Else pkt_valid=0: go to LOAD_PARITY.
  - Else stay. fifo_full has priority over pkt_valid falling.
- FIFO_FULL_STATE: fifo_full=0 goes to LOAD_AFTER_FULL; otherwise stay.
- LOAD_AFTER_FULL:
  - parity_done=1: go to DECODE_ADDRESS.
  - Else low_pkt_valid=1: go to LOAD_PARITY.
  - Else go to LOAD_DATA.
- LOAD_PARITY: go to CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full=1 goes to FIFO_FULL_STATE; otherwise DECODE_ADDRESS.
- Output decode:
  - write_enb_reg=1 in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
  - busy=1 in LOAD_FIRST_DATA, WAIT_TILL_EMPTY, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY and CHECK_PARITY_ERROR.
  - busy=0 in DECODE_ADDRESS and LOAD_DATA.
- Latency: the header byte accepted in DECODE_ADDRESS yields lfd_state=1 on the next cycle (empty target) and ld_state=1 one cycle later.
- Reset mid-packet: state and address latch clear immediately (asynchronous). Outputs return to reset values with no clock edge.
- Back-to-back packets: a new header may be accepted on the first cycle after CHECK_PARITY_ERROR or LOAD_AFTER_FULL returns to DECODE_ADDRESS.

Test Plan:
- Reset with state=LOAD_DATA -> detect_add=1, ld_state=0, busy=0 asynchronously, before the next edge.
- Header data_in=2'b01 with pkt_valid=1 and fifo_empty_1=1, 5 payload cycles, then pkt_valid=0 -> state sequence DECODE, LFD, LD x5, LOAD_PARITY, CHECK, DECODE; write_enb_reg=1 for 6 cycles; busy=1 during LFD, LOAD_PARITY, CHECK.
- Header data_in=2'b10 with fifo_empty_2=0 for 4 cycles, then 1 -> WAIT_TILL_EMPTY for 4 cycles with busy=1, then LFD.
- In LD, fifo_full=1 for 3 cycles, then 0, with low_pkt_valid=1 -> FIFO_FULL_STATE x3, LAF (laf_state=1, write_enb_reg=1), LOAD_PARITY. Repeat with low_pkt_valid=0 -> returns to LD.
- Latched address=0 in WAIT_TILL_EMPTY: soft_reset_1=1 -> no change; soft_reset_0=1 -> DECODE_ADDRESS next cycle, detect_add=1.
- Header data_in=2'b11 with pkt_valid=1 -> remains in DECODE_ADDRESS, address latch unchanged, write_enb_reg=0.

Source files
------------

// File: rtl/router_fsm_ctrl_if.sv
// Handshake bundle between the 1x3 router packet-flow controller and its neighbours
// (source, register block, synchronizer and output FIFOs).
interface router_fsm_ctrl_if;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0;
   logic       fifo_empty_1;
   logic       fifo_empty_2;
   logic       soft_reset_0;
   logic       soft_reset_1;
   logic       soft_reset_2;
   logic       parity_done;
   logic       low_pkt_valid;

   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       write_enb_reg;
   logic       rst_int_reg;
   logic       busy;

   modport master (
      output pkt_valid, data_in, fifo_full,
      output fifo_empty_0, fifo_empty_1, fifo_empty_2,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output parity_done, low_pkt_valid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state,
      input  write_enb_reg, rst_int_reg, busy
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  parity_done, low_pkt_valid,
      output detect_add, lfd_state, ld_state, laf_state, full_state,
      output write_enb_reg, rst_int_reg, busy
   );
endinterface

// File: rtl/router_fsm_ctrl.sv
// Packet-flow controller for the 1x3 router: sequences header decode, payload load,
// full-stall recovery and parity handling; all outputs are Moore.
//
// state              | meaning
// -------------------+-------------------------------------------------------
// DECODE_ADDRESS     | idle, waiting for a header byte with a valid address
// WAIT_TILL_EMPTY    | addressed FIFO still holds an older packet
// LOAD_FIRST_DATA    | header byte written into the addressed FIFO
// LOAD_DATA          | payload bytes streaming into the FIFO
// FIFO_FULL_STATE    | addressed FIFO full, source stalled
// LOAD_AFTER_FULL    | FIFO drained, write the byte held during the stall
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | parity compared; may still stall if FIFO filled up
module router_fsm_ctrl (
   input  logic               clk,
   input  logic               reset,
   router_fsm_ctrl_if.slave   ctl
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      WAIT_TILL_EMPTY    = 3'd1,
      LOAD_FIRST_DATA    = 3'd2,
      LOAD_DATA          = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      LOAD_PARITY        = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] addr_q, addr_d;
   logic       addr_soft_rst;
   logic       addr_empty;
   logic       hdr_empty;

   // Status of the port latched for the packet in flight.
   always_comb begin
      addr_soft_rst = 1'b0;
      addr_empty    = 1'b0;
      case (addr_q)
         2'd0: begin addr_soft_rst = ctl.soft_reset_0; addr_empty = ctl.fifo_empty_0; end
         2'd1: begin addr_soft_rst = ctl.soft_reset_1; addr_empty = ctl.fifo_empty_1; end
         2'd2: begin addr_soft_rst = ctl.soft_reset_2; addr_empty = ctl.fifo_empty_2; end
         default: begin addr_soft_rst = 1'b0; addr_empty = 1'b0; end
      endcase
   end

   always_comb begin
      hdr_empty = 1'b0;
      case (ctl.data_in)
         2'd0:    hdr_empty = ctl.fifo_empty_0;
         2'd1:    hdr_empty = ctl.fifo_empty_1;
         2'd2:    hdr_empty = ctl.fifo_empty_2;
         default: hdr_empty = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if ((state_q != DECODE_ADDRESS) && addr_soft_rst) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS: begin
               if (ctl.pkt_valid && (ctl.data_in != 2'b11)) begin
                  addr_d  = ctl.data_in;
                  state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
               end
            end
            WAIT_TILL_EMPTY: begin
               if (addr_empty) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
               if (ctl.fifo_full)       state_d = FIFO_FULL_STATE;
               else if (!ctl.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
               if (!ctl.fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (ctl.parity_done)        state_d = DECODE_ADDRESS;
               else if (ctl.low_pkt_valid) state_d = LOAD_PARITY;
               else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
               state_d = ctl.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
         endcase
      end
   end

   // Source is only free to advance while idle or streaming payload.
   always_comb begin
      ctl.detect_add    = (state_q == DECODE_ADDRESS);
      ctl.lfd_state     = (state_q == LOAD_FIRST_DATA);
      ctl.ld_state      = (state_q == LOAD_DATA);
      ctl.laf_state     = (state_q == LOAD_AFTER_FULL);
      ctl.full_state    = (state_q == FIFO_FULL_STATE);
      ctl.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
      ctl.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                          (state_q == LOAD_AFTER_FULL);
      ctl.busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
   end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Bench for router_fsm_ctrl: directed packet scenarios with literal output codes,
// then randomized traffic compared every cycle against a phase-level reference model.
module tb_router_fsm_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   router_fsm_ctrl_if bus();

   router_fsm_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (bus)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   localparam int P_DEC  = 0;
   localparam int P_WAIT = 1;
   localparam int P_LFD  = 2;
   localparam int P_LD   = 3;
   localparam int P_FULL = 4;
   localparam int P_LAF  = 5;
   localparam int P_LP   = 6;
   localparam int P_CHK  = 7;

   int         m_phase;
   logic [1:0] m_addr;

   // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
   wire [7:0] dut_o = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                       bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};

   function automatic logic [7:0] exp_out(int ph);
      logic [7:0] v;
      v    = '0;
      v[7] = (ph == P_DEC);
      v[6] = (ph == P_LFD);
      v[5] = (ph == P_LD);
      v[4] = (ph == P_LAF);
      v[3] = (ph == P_FULL);
      v[2] = (ph == P_LD) || (ph == P_LP) || (ph == P_LAF);
      v[1] = (ph == P_CHK);
      v[0] = !((ph == P_DEC) || (ph == P_LD));
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: packet phase advanced from the flow rules.
   always @(posedge clk or posedge reset) begin : mdl
      int         nx;
      logic [3:0] sr;
      logic [3:0] fe;
      if (reset) begin
         m_phase <= P_DEC;
         m_addr  <= 2'd0;
      end else begin
         sr = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
         fe = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
         nx = m_phase;
         if (m_phase != P_DEC && sr[m_addr]) nx = P_DEC;
         else begin
            case (m_phase)
               P_DEC: if (bus.pkt_valid && bus.data_in != 2'd3) begin
                  m_addr <= bus.data_in;
                  nx = fe[bus.data_in] ? P_LFD : P_WAIT;
               end
               P_WAIT: if (fe[m_addr]) nx = P_LFD;
               P_LFD:  nx = P_LD;
               P_LD:   nx = bus.fifo_full ? P_FULL : (!bus.pkt_valid ? P_LP : P_LD);
               P_FULL: if (!bus.fifo_full) nx = P_LAF;
               P_LAF:  nx = bus.parity_done ? P_DEC : (bus.low_pkt_valid ? P_LP : P_LD);
               P_LP:   nx = P_CHK;
               P_CHK:  nx = bus.fifo_full ? P_FULL : P_DEC;
               default: nx = P_DEC;
            endcase
         end
         m_phase <= nx;
      end
   end

   always @(negedge clk) begin
      if (chk_en) chk("cycle", dut_o, exp_out(m_phase));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic lit(input string nm, input logic [7:0] v);
      chk({nm, "_dut"}, dut_o, v);
      chk({nm, "_mdl"}, exp_out(m_phase), v);
   endtask

   task automatic idle_inputs();
      bus.pkt_valid     = 1'b0;
      bus.data_in       = 2'd0;
      bus.fifo_full     = 1'b0;
      bus.fifo_empty_0  = 1'b1;
      bus.fifo_empty_1  = 1'b1;
      bus.fifo_empty_2  = 1'b1;
      bus.soft_reset_0  = 1'b0;
      bus.soft_reset_1  = 1'b0;
      bus.soft_reset_2  = 1'b0;
      bus.parity_done   = 1'b0;
      bus.low_pkt_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      lit("reset", 8'h80);

      // Asynchronous reset from LOAD_DATA, observed before the next edge
      bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
      tick(); lit("ar_lfd", 8'h41);
      tick(); lit("ar_ld", 8'h24);
      #1 reset = 1'b1;
      #1 lit("ar_async", 8'h80);
      tick(); reset = 1'b0; idle_inputs();
      tick(); lit("ar_after", 8'h80);

      // Port 1 packet, 5 payload cycles
      bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
      tick(); lit("p1_lfd", 8'h41);
      tick();
      for (int i = 0; i < 5; i++) begin
         lit("p1_ld", 8'h24);
         if (i == 4) bus.pkt_valid = 1'b0;
         tick();
      end
      lit("p1_lp", 8'h05);
      tick(); lit("p1_chk", 8'h03);
      tick(); lit("p1_dec", 8'h80);

      // Port 2 busy for 4 cycles
      bus.pkt_valid = 1'b1; bus.data_in = 2'd2; bus.fifo_empty_2 = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         lit("p2_wait", 8'h01);
         if (i == 3) bus.fifo_empty_2 = 1'b1;
         tick();
      end
      lit("p2_lfd", 8'h41);
      tick(); lit("p2_ld", 8'h24);

      // Full stall with low_pkt_valid -> LOAD_PARITY
      bus.fifo_full = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         lit("fs1_full", 8'h09);
         if (i == 2) begin bus.fifo_full = 1'b0; bus.low_pkt_valid = 1'b1; end
         tick();
      end
      lit("fs1_laf", 8'h15);
      tick(); lit("fs1_lp", 8'h05);
      bus.low_pkt_valid = 1'b0;
      tick(); lit("fs1_chk", 8'h03);
      tick(); lit("fs1_dec", 8'h80);

      // Full stall without low_pkt_valid -> back to LOAD_DATA
      bus.data_in = 2'd0;
      tick(); tick(); lit("fs2_ld", 8'h24);
      bus.fifo_full = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         lit("fs2_full", 8'h09);
         if (i == 2) bus.fifo_full = 1'b0;
         tick();
      end
      lit("fs2_laf", 8'h15);
      tick(); lit("fs2_ld2", 8'h24);
      bus.pkt_valid = 1'b0;
      tick(); tick(); tick(); lit("fs2_dec", 8'h80);

      // Soft reset of a non-addressed port is ignored
      bus.pkt_valid = 1'b1; bus.data_in = 2'd0; bus.fifo_empty_0 = 1'b0;
      tick(); lit("sr_wait", 8'h01);
      bus.soft_reset_1 = 1'b1;
      tick(); lit("sr_other", 8'h01);
      bus.soft_reset_1 = 1'b0; bus.soft_reset_0 = 1'b1;
      tick(); lit("sr_own", 8'h80);
      idle_inputs();

      // Invalid address 3 is never accepted
      bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
      tick(); lit("a3_dec", 8'h80);
      tick(); lit("a3_dec2", 8'h80);
      idle_inputs();
      tick();

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         bus.pkt_valid     = ($urandom_range(0, 9) < 8);
         bus.data_in       = 2'($urandom_range(0, 3));
         bus.fifo_full     = ($urandom_range(0, 4) == 0);
         bus.fifo_empty_0  = ($urandom_range(0, 3) != 0);
         bus.fifo_empty_1  = ($urandom_range(0, 3) != 0);
         bus.fifo_empty_2  = ($urandom_range(0, 3) != 0);
         bus.soft_reset_0  = ($urandom_range(0, 29) == 0);
         bus.soft_reset_1  = ($urandom_range(0, 29) == 0);
         bus.soft_reset_2  = ($urandom_range(0, 29) == 0);
         bus.parity_done   = ($urandom_range(0, 5) == 0);
         bus.low_pkt_valid = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 499) == 0) begin
            reset = 1'b1;
            #1 reset = 1'b0;
         end
         tick();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
